// File: rtl/ho_pkg.sv
// ho_pkg: types and helpers shared by the uplink transmitter and its FIFO.
//   NUM_BS     : number of base stations the device can be served by
//   bs_idx_t   : base-station index (0..NUM_BS-1)
//   ul_state_t : handover controller states
//   onehot3()  : converts a BS index into the one-hot select used on the
//                per-BS valid / request buses (bit0 = BS1)
package ho_pkg;

    localparam int NUM_BS = 3;

    typedef logic [1:0] bs_idx_t;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        DRAIN  = 2'd1,
        HO_REQ = 2'd2
    } ul_state_t;

    function automatic logic [NUM_BS-1:0] onehot3(input bs_idx_t idx);
        logic [NUM_BS-1:0] v;
        v = '0;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ul_fifo.sv
// ul_fifo: small synchronous FIFO buffering device words on the uplink.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset, empties the FIFO
//   i_push   : write i_data (ignored when full)
//   i_data   : word to write
//   i_pop    : discard the head word (ignored when empty)
//   o_full   : FIFO_DEPTH words held
//   o_empty  : no words held
//   o_head   : oldest word (valid when !o_empty)
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module ul_fifo #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: contents are only meaningful behind r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/md_uplink_tx.sv
// md_uplink_tx: mobile-device uplink transmitter.
// Buffers device words and sends them to exactly one serving base station.
// The serving BS is chosen from three link-quality inputs with hysteresis;
// before switching, the buffer is drained to the old BS and a
// request/acknowledge handover is run with the target BS.
// Ports:
//   clk, reset                  : clock (rising edge), async active-low reset
//   md_valid/md_data/md_ready   : device word intake handshake
//   signalquality1..3           : BS1..BS3 link quality
//   ul_valid[2:0]/ul_data       : one-hot valid and word toward the serving BS
//   ul_ready[2:0]               : per-BS ready (only the serving bit matters)
//   ho_req[2:0]/ho_ack[2:0]     : one-hot handover request / per-BS acknowledge
//   serving_bs                  : current serving BS index (0..2)
//   ho_busy                     : draining or waiting for a handover ack
//   ho_fail                     : one-cycle pulse when a handover times out
module md_uplink_tx
    import ho_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int SQ_W       = 8,
    parameter int HYST       = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int HO_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              md_valid,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    input  logic [SQ_W-1:0]   signalquality1,
    input  logic [SQ_W-1:0]   signalquality2,
    input  logic [SQ_W-1:0]   signalquality3,
    output logic [2:0]        ul_valid,
    output logic [DATA_W-1:0] ul_data,
    input  logic [2:0]        ul_ready,
    output logic [2:0]        ho_req,
    input  logic [2:0]        ho_ack,
    output logic [1:0]        serving_bs,
    output logic              ho_busy,
    output logic              ho_fail
);

    localparam int CNT_W = (HO_TIMEOUT > 1) ? $clog2(HO_TIMEOUT) : 1;
    localparam int SQX_W = SQ_W + 1;
    localparam logic [SQX_W-1:0] HYST_X = SQX_W'(HYST);

    ul_state_t         r_state;
    bs_idx_t           r_serving;
    bs_idx_t           r_target;
    logic [2:0]        r_ho_req;
    logic              r_ho_fail;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    bs_idx_t           w_cand;
    logic [SQ_W-1:0]   w_best_q;
    logic [SQ_W-1:0]   w_serv_q;
    logic [SQX_W-1:0]  w_threshold;
    logic              w_trigger;
    logic              w_ack;

    ul_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (md_data),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Intake only while serving; the FIFO drains to the old BS otherwise.
    assign md_ready   = ~w_full & (r_state == SERVE);
    assign w_push     = md_valid & md_ready;
    assign ul_valid   = (!w_empty && (r_state != HO_REQ)) ? onehot3(r_serving) : 3'b000;
    // Masking with ul_valid leaves only the serving BS's ready bit effective.
    assign w_pop      = |(ul_valid & ul_ready);
    assign ul_data    = w_head;
    assign ho_req     = r_ho_req;
    assign ho_fail    = r_ho_fail;
    assign serving_bs = r_serving;
    assign ho_busy    = (r_state != SERVE);
    assign w_ack      = |(ho_ack & onehot3(r_target));

    // Argmax with strict '>' so ties resolve to the lowest index.
    always_comb begin
        w_cand   = 2'd0;
        w_best_q = signalquality1;
        if (signalquality2 > w_best_q) begin
            w_cand   = 2'd1;
            w_best_q = signalquality2;
        end
        if (signalquality3 > w_best_q) begin
            w_cand   = 2'd2;
            w_best_q = signalquality3;
        end
    end

    always_comb begin
        case (r_serving)
            2'd1:    w_serv_q = signalquality2;
            2'd2:    w_serv_q = signalquality3;
            default: w_serv_q = signalquality1;
        endcase
    end

    // One extra bit keeps serving quality + margin from wrapping.
    assign w_threshold = {1'b0, w_serv_q} + HYST_X;
    assign w_trigger   = (w_cand != r_serving) && ({1'b0, w_best_q} >= w_threshold);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= SERVE;
            r_serving <= 2'd0;
            r_target  <= 2'd0;
            r_ho_req  <= 3'b000;
            r_ho_fail <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_ho_fail <= 1'b0;
            case (r_state)
                SERVE: begin
                    if (w_trigger) begin
                        r_target <= w_cand;
                        r_state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Target is frozen; quality changes here are ignored.
                    if (w_empty) begin
                        r_cnt    <= '0;
                        r_ho_req <= onehot3(r_target);
                        r_state  <= HO_REQ;
                    end
                end
                HO_REQ: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (w_ack) begin
                        r_serving <= r_target;
                        r_ho_req  <= 3'b000;
                        r_state   <= SERVE;
                    end else if (r_cnt == CNT_W'(HO_TIMEOUT - 1)) begin
                        r_ho_fail <= 1'b1;
                        r_ho_req  <= 3'b000;
                        r_state   <= SERVE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_ho_req <= 3'b000;
                    r_state  <= SERVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_uplink_tx.sv
// Testbench for md_uplink_tx: directed scenarios plus randomized rounds.
// A monitor scoreboards every uplink word (order, data, destination BS);
// handover outcomes are predicted by an argmax/hysteresis model.
module tb_md_uplink_tx;

    localparam int DATA_W     = 4;
    localparam int SQ_W       = 8;
    localparam int HYST       = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int HO_TIMEOUT = 16;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              md_valid = 1'b0;
    logic [DATA_W-1:0] md_data  = '0;
    logic              md_ready;
    logic [SQ_W-1:0]   signalquality1 = '0;
    logic [SQ_W-1:0]   signalquality2 = '0;
    logic [SQ_W-1:0]   signalquality3 = '0;
    logic [2:0]        ul_valid;
    logic [DATA_W-1:0] ul_data;
    logic [2:0]        ul_ready = 3'b000;
    logic [2:0]        ho_req;
    logic [2:0]        ho_ack = 3'b000;
    logic [1:0]        serving_bs;
    logic              ho_busy;
    logic              ho_fail;

    md_uplink_tx #(
        .DATA_W     (DATA_W),
        .SQ_W       (SQ_W),
        .HYST       (HYST),
        .FIFO_DEPTH (FIFO_DEPTH),
        .HO_TIMEOUT (HO_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .md_valid       (md_valid),
        .md_data        (md_data),
        .md_ready       (md_ready),
        .signalquality1 (signalquality1),
        .signalquality2 (signalquality2),
        .signalquality3 (signalquality3),
        .ul_valid       (ul_valid),
        .ul_data        (ul_data),
        .ul_ready       (ul_ready),
        .ho_req         (ho_req),
        .ho_ack         (ho_ack),
        .serving_bs     (serving_bs),
        .ho_busy        (ho_busy),
        .ho_fail        (ho_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int bs;
    } exp_t;

    exp_t sb_q[$];
    int   m_serv = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: serve the best link (lowest index on ties) only when it
    // beats the current one by at least HYST. Returns -1 for "stay".
    function automatic int model_target(input int serv, input int q1, input int q2, input int q3);
        int sq[3];
        int best;
        sq[0] = q1; sq[1] = q2; sq[2] = q3;
        best = 0;
        for (int i = 1; i < 3; i++) if (sq[i] > sq[best]) best = i;
        if (best != serv && sq[best] >= sq[serv] + HYST) return best;
        return -1;
    endfunction

    // Monitor: every word the device hands over must come out once, in order,
    // toward the BS that was serving when it was accepted.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            chk("ul_valid_vs_backlog", int'(ul_valid != 3'b000), int'(sb_q.size() != 0));
            if ((ul_valid & ul_ready) != 3'b000) begin
                chk("pop_has_expected_word", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("ul_valid_dest", int'(ul_valid), 1 << e.bs);
                    chk("ul_data", int'(ul_data), e.data);
                end
            end
            if (md_valid && md_ready) begin
                e.data = int'(md_data);
                e.bs   = m_serv;
                sb_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sq(input int a, input int b, input int c);
        signalquality1 = SQ_W'(a);
        signalquality2 = SQ_W'(b);
        signalquality3 = SQ_W'(c);
    endtask

    task automatic traffic(input int n);
        for (int i = 0; i < n; i++) begin
            md_valid = 1'($urandom);
            md_data  = DATA_W'($urandom);
            ul_ready = 3'($urandom);
            step();
        end
        md_valid = 1'b0;
    endtask

    task automatic wait_req(input int rand_traffic, output int seen);
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            if (ho_req != 3'b000) seen = 1;
            else begin
                if (rand_traffic != 0) begin
                    md_valid = 1'($urandom);
                    md_data  = DATA_W'($urandom);
                    ul_ready = 3'($urandom);
                end
                step();
            end
        end
        md_valid = 1'b0;
        chk("ho_req_raised", seen, 1);
    endtask

    task automatic do_handover(input int tgt, input int ack_delay, input int rand_traffic);
        int seen;
        wait_req(rand_traffic, seen);
        if (seen != 0) begin
            chk("ho_req_onehot", int'(ho_req), 1 << tgt);
            chk("ho_busy_in_req", int'(ho_busy), 1);
            chk("md_ready_in_req", int'(md_ready), 0);
            chk("drained_before_req", sb_q.size(), 0);
            for (int k = 0; k < ack_delay; k++) begin
                ho_ack = 3'($urandom) & ~3'(1 << tgt);
                step();
            end
            chk("ho_req_held", int'(ho_req), 1 << tgt);
            chk("serving_before_ack", int'(serving_bs), m_serv);
            ho_ack = 3'(1 << tgt);
            step();
            ho_ack = 3'b000;
            m_serv = tgt;
            chk("serving_after_ack", int'(serving_bs), tgt);
            chk("ho_req_cleared", int'(ho_req), 0);
            chk("ho_busy_after_ack", int'(ho_busy), 0);
            chk("md_ready_after_ack", int'(md_ready), 1);
        end
    endtask

    task automatic drain_all();
        ul_ready = 3'b111;
        md_valid = 1'b0;
        for (int i = 0; i < 30 && sb_q.size() > 0; i++) step();
        chk("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        int t1w[3];
        int tgt;
        int seen;
        int cnt;
        int q1, q2, q3;

        // Reset values, before any clock edge
        set_sq(70, 30, 20);
        #1 reset = 1'b0;
        #2;
        chk("rst_ho_req", int'(ho_req), 0);
        chk("rst_ul_valid", int'(ul_valid), 0);
        chk("rst_serving", int'(serving_bs), 0);
        chk("rst_ho_busy", int'(ho_busy), 0);
        chk("rst_ho_fail", int'(ho_fail), 0);
        step();
        step();
        reset = 1'b1;
        m_serv = 0;
        chk("md_ready_after_rst", int'(md_ready), 1);

        // Basic serving on BS1, one-cycle latency
        t1w[0] = 2; t1w[1] = 5; t1w[2] = 7;
        ul_ready = 3'b001;
        for (int i = 0; i < 3; i++) begin
            md_valid = 1'b1;
            md_data  = DATA_W'(t1w[i]);
            step();
            chk("t1_ul_data", int'(ul_data), t1w[i]);
            chk("t1_ul_valid", int'(ul_valid), 1);
            chk("t1_ho_busy", int'(ho_busy), 0);
        end
        md_valid = 1'b0;
        step();
        step();

        // Handover with three words buffered
        ul_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            md_valid = 1'b1;
            md_data  = DATA_W'($urandom);
            step();
        end
        md_valid = 1'b0;
        set_sq(30, 90, 30);
        ul_ready = 3'b001;
        step();
        chk("t2_busy_drain", int'(ho_busy), 1);
        chk("t2_md_ready_drain", int'(md_ready), 0);
        tgt = model_target(m_serv, 30, 90, 30);
        do_handover(tgt, 3, 0);
        md_valid = 1'b1;
        md_data  = DATA_W'(3);
        ul_ready = 3'b010;
        step();
        chk("t2_new_valid", int'(ul_valid), 3'b010);
        chk("t2_new_data", int'(ul_data), 3);
        md_valid = 1'b0;
        step();

        // Hysteresis: just below the margin, exactly at it, then a tie
        set_sq(20, 70, 79);
        traffic(20);
        chk("t3_no_ho_serving", int'(serving_bs), m_serv);
        chk("t3_no_ho_busy", int'(ho_busy), 0);
        set_sq(20, 70, 80);
        do_handover(model_target(m_serv, 20, 70, 80), 1, 1);
        set_sq(90, 90, 70);
        do_handover(model_target(m_serv, 90, 90, 70), 2, 1);

        // Full FIFO and simultaneous push/pop
        set_sq(200, 0, 0);
        drain_all();
        ul_ready = 3'b000;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            md_valid = 1'b1;
            md_data  = DATA_W'($urandom);
            step();
        end
        chk("t5_full_ready", int'(md_ready), 0);
        ul_ready = 3'(1 << m_serv);
        md_data  = DATA_W'($urandom);
        step();
        chk("t5_after_pop_ready", int'(md_ready), 1);
        md_data  = DATA_W'($urandom);
        step();
        chk("t5_push_pop_ready", int'(md_ready), 1);
        ul_ready = 3'b000;
        md_data  = DATA_W'($urandom);
        step();
        chk("t5_refull_ready", int'(md_ready), 0);
        drain_all();

        // Timeout with ack withheld, then the persistent condition retriggers
        set_sq(10, 10, 90);
        tgt = model_target(m_serv, 10, 10, 90);
        wait_req(0, seen);
        cnt = 0;
        while (ho_req == 3'(1 << tgt) && cnt < 40) begin
            cnt++;
            step();
        end
        chk("t4_req_cycles", cnt, HO_TIMEOUT);
        chk("t4_fail_pulse", int'(ho_fail), 1);
        chk("t4_serving_kept", int'(serving_bs), m_serv);
        chk("t4_req_dropped", int'(ho_req), 0);
        step();
        chk("t4_fail_one_cycle", int'(ho_fail), 0);
        do_handover(tgt, 1, 0);

        // Asynchronous reset in the middle of a handover request
        set_sq(200, 0, 0);
        ul_ready = 3'b111;
        wait_req(0, seen);
        chk("t6_req_target", int'(ho_req), 1 << model_target(m_serv, 200, 0, 0));
        reset = 1'b0;
        sb_q.delete();
        m_serv = 0;
        #2;
        chk("t6_ho_req", int'(ho_req), 0);
        chk("t6_serving", int'(serving_bs), 0);
        chk("t6_ul_valid", int'(ul_valid), 0);
        chk("t6_ho_busy", int'(ho_busy), 0);
        step();
        reset = 1'b1;
        // Buffered words are discarded by a reset as well
        ul_ready = 3'b000;
        for (int i = 0; i < 2; i++) begin
            md_valid = 1'b1;
            md_data  = DATA_W'($urandom);
            step();
        end
        md_valid = 1'b0;
        reset = 1'b0;
        sb_q.delete();
        #2;
        chk("t6_flush_valid", int'(ul_valid), 0);
        step();
        reset = 1'b1;
        ul_ready = 3'b111;
        step();
        chk("t6_still_empty", int'(ul_valid), 0);

        // Randomized rounds
        for (int r = 0; r < 20; r++) begin
            q1 = $urandom_range(0, 255);
            q2 = $urandom_range(0, 255);
            q3 = $urandom_range(0, 255);
            set_sq(q1, q2, q3);
            tgt = model_target(m_serv, q1, q2, q3);
            if (tgt < 0) begin
                traffic(12);
                chk("rnd_serving", int'(serving_bs), m_serv);
                chk("rnd_not_busy", int'(ho_busy), 0);
            end else begin
                traffic(3);
                do_handover(tgt, $urandom_range(0, 3), 1);
            end
        end
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
